imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter: ADDR_WORDS, 32, number of 32-bit words in the attached instruction memory.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive lost arbitration cycles after which the debug port is forced to win.
REQ-003 clk_i  input  1  single clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 f_req_i  input  1  fetch port read request; held with f_addr_i until granted.
REQ-006 f_addr_i  input  32  fetch port byte address.
REQ-007 f_gnt_o  output  1  fetch port grant, combinational, same cycle as selection.
REQ-008 f_valid_o  output  1  fetch read data valid, registered, one cycle after f_gnt_o.
REQ-009 f_err_o  output  1  fetch access error, qualified by f_valid_o.
REQ-010 d_req_i  input  1  debug/loader port read request; held with d_addr_i until granted.
REQ-011 d_addr_i  input  32  debug port byte address.
REQ-012 d_lock_i  input  1  debug requests exclusive ownership across consecutive accesses.
REQ-013 d_gnt_o  output  1  debug port grant, combinational.
REQ-014 d_valid_o  output  1  debug read data valid, registered.
REQ-015 d_err_o  output  1  debug access error, qualified by d_valid_o.
REQ-016 rdata_o  output  32  registered read data, shared by both ports; meaningful only with f_valid_o or d_valid_o.
REQ-017 mem_addr_o  output  32  byte address to the instruction memory, combinational from the granted port.
REQ-018 mem_instr_i  input  32  combinational read data returned by the instruction memory for mem_addr_o.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, DEBUG, LOCKED; state reflects the owner of the previous cycle's grant.
REQ-020 At most one of f_gnt_o, d_gnt_o SHALL be high in any cycle; no grant when the winning req is low.
REQ-021 Default priority: fetch wins when both requests are high.
REQ-022 Starvation counter SHALL increment each cycle d_req_i is high and fetch is granted, clear on any debug grant or d_req_i low, saturate at STARVE_LIMIT.
REQ-023 When the counter equals STARVE_LIMIT and d_req_i is high, debug SHALL win regardless of f_req_i.
REQ-024 Debug grant with d_lock_i high SHALL move to LOCKED; in LOCKED fetch SHALL NOT be granted, debug granted whenever d_req_i is high.
REQ-025 LOCKED exits to IDLE on the first edge with d_lock_i low; if that cycle has both requests, fetch wins (normal priority).
REQ-026 A grant in FETCH/DEBUG returns to IDLE on the next edge if no request is granted; otherwise state follows the winner.
REQ-027 mem_addr_o SHALL equal the granted port's address; equal to f_addr_i when no grant.
REQ-028 Read latency: grant in cycle N -> rdata_o and the matching valid_o high for exactly cycle N+1; back-to-back grants give one result per cycle.
REQ-029 Error when the granted address has bits [1:0] non-zero or address/4 >= ADDR_WORDS; on error rdata_o SHALL be 32'h0 and err_o high with valid_o.
REQ-030 Index arithmetic SHALL use address bits [31:2]; no wrap-around of out-of-range addresses.
REQ-031 rdata_o SHALL hold its last value when neither valid_o is high.

Reset
REQ-032 While rst_i is low: state IDLE, starvation counter 0, f_valid_o, d_valid_o, f_err_o, d_err_o 0, rdata_o 32'h0; grants forced low.
REQ-033 Reset asserted mid-access SHALL discard the pending response; no valid_o pulse after rst_i rises until a new grant.

Verification
REQ-034 Fetch only, f_addr_i=0,4,8 on consecutive cycles -> f_gnt_o each cycle, f_valid_o cycles 1-3, rdata_o = words 0,1,2.
REQ-035 Both request continuously, STARVE_LIMIT=4 -> f_gnt_o 4 cycles, d_gnt_o on cycle 5, fetch again cycle 6.
REQ-036 d_lock_i high, d_req_i 3 cycles with f_req_i high -> d_gnt_o 3 cycles, f_gnt_o 0; d_lock_i low -> fetch granted next cycle.
REQ-037 f_addr_i=32'h2 then 32'h80 -> f_valid_o with f_err_o=1, rdata_o=0 both times.
REQ-038 rst_i low in cycle after grant -> no f_valid_o, all outputs 0; after release idle until new request.

Source files
------------

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Two-port read arbiter in front of a single-ported instruction memory.
//   The fetch port has default priority. The debug/loader port wins once it
//   has been starved for STARVE_LIMIT consecutive cycles. It can also lock
//   the memory for a run of accesses using d_lock_i.
//
// Ports
//   clk_i, rst_i          clock; asynchronous active-low reset
//   f_req_i, f_addr_i     fetch request and byte address (held until granted)
//   f_gnt_o               fetch grant (combinational)
//   f_valid_o, f_err_o    fetch response valid / access error (registered)
//   d_req_i, d_addr_i     debug request and byte address (held until granted)
//   d_lock_i              debug requests exclusive ownership
//   d_gnt_o               debug grant (combinational)
//   d_valid_o, d_err_o    debug response valid / access error (registered)
//   rdata_o               shared registered read data
//   mem_addr_o            byte address presented to the memory
//   mem_instr_i           combinational memory read data for mem_addr_o
module imem_arbiter #(
    parameter int unsigned ADDR_WORDS   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_req_i,
    input  logic [31:0] f_addr_i,
    output logic        f_gnt_o,
    output logic        f_valid_o,
    output logic        f_err_o,
    input  logic        d_req_i,
    input  logic [31:0] d_addr_i,
    input  logic        d_lock_i,
    output logic        d_gnt_o,
    output logic        d_valid_o,
    output logic        d_err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DEBUG  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    localparam int unsigned CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [30:0]      WORD_LIM   = 31'(ADDR_WORDS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             acc_err;

    // Arbitration and next state. Grants are gated by reset so nothing is
    // granted while rst_i is low.
    always_comb begin
        f_gnt_o   = 1'b0;
        d_gnt_o   = 1'b0;
        state_nxt = state;
        if (!rst_i) begin
            state_nxt = IDLE;
        end else if (state == LOCKED) begin
            // Fetch is shut out for the whole locked cycle. The lock is
            // released at the edge after d_lock_i drops. Normal priority
            // resumes from IDLE on the following cycle.
            d_gnt_o   = d_req_i;
            state_nxt = d_lock_i ? LOCKED : IDLE;
        end else begin
            if (d_req_i && (starve_cnt == STARVE_MAX || !f_req_i))
                d_gnt_o = 1'b1;
            else if (f_req_i)
                f_gnt_o = 1'b1;

            if (d_gnt_o)
                state_nxt = d_lock_i ? LOCKED : DEBUG;
            else if (f_gnt_o)
                state_nxt = FETCH;
            else
                state_nxt = IDLE;
        end
    end

    always_comb begin
        mem_addr_o = d_gnt_o ? d_addr_i : f_addr_i;
        // Word index comes from bits [31:2] only. An out-of-range index
        // is flagged as an error and is never wrapped.
        acc_err    = (mem_addr_o[1:0] != 2'b00) ||
                     ({1'b0, mem_addr_o[31:2]} >= WORD_LIM);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (d_gnt_o || !d_req_i)
                starve_cnt <= '0;
            else if (f_gnt_o && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            f_valid_o <= 1'b0;
            d_valid_o <= 1'b0;
            f_err_o   <= 1'b0;
            d_err_o   <= 1'b0;
            rdata_o   <= '0;
        end else begin
            f_valid_o <= f_gnt_o;
            d_valid_o <= d_gnt_o;
            f_err_o   <= f_gnt_o && acc_err;
            d_err_o   <= d_gnt_o && acc_err;
            if (f_gnt_o || d_gnt_o)
                rdata_o <= acc_err ? '0 : mem_instr_i;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Directed, scoreboard-based bench for imem_arbiter. A behavioural memory
//   model answers mem_addr_o. Expected responses are queued when a grant is
//   observed and are compared when the registered response appears.
module tb_imem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        f_req_i, d_req_i, d_lock_i;
    logic [31:0] f_addr_i, d_addr_i;
    logic        f_gnt_o, f_valid_o, f_err_o;
    logic        d_gnt_o, d_valid_o, d_err_o;
    logic [31:0] rdata_o, mem_addr_o, mem_instr_i;

    typedef struct {
        bit          is_d;
        bit          err;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rdata = '0;

    always #5 clk_i = ~clk_i;

    imem_arbiter #(.ADDR_WORDS(32), .STARVE_LIMIT(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .f_req_i    (f_req_i),
        .f_addr_i   (f_addr_i),
        .f_gnt_o    (f_gnt_o),
        .f_valid_o  (f_valid_o),
        .f_err_o    (f_err_o),
        .d_req_i    (d_req_i),
        .d_addr_i   (d_addr_i),
        .d_lock_i   (d_lock_i),
        .d_gnt_o    (d_gnt_o),
        .d_valid_o  (d_valid_o),
        .d_err_o    (d_err_o),
        .rdata_o    (rdata_o),
        .mem_addr_o (mem_addr_o),
        .mem_instr_i(mem_instr_i)
    );

    function automatic logic [31:0] word_val(input logic [29:0] idx);
        return {16'hC0DE, 16'(idx * 7 + 1)};
    endfunction

    // Out-of-range reads return junk so that a missing error clamp shows up.
    always_comb begin
        if (mem_addr_o[31:2] < 30'd32)
            mem_instr_i = word_val(mem_addr_o[31:2]);
        else
            mem_instr_i = 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic resp_t expect_for(input bit is_d, input logic [31:0] addr);
        resp_t r;
        r.is_d = is_d;
        r.err  = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd32);
        r.data = r.err ? 32'h0 : word_val(addr[31:2]);
        return r;
    endfunction

    task automatic check_resp();
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("f_valid", {31'b0, f_valid_o}, {31'b0, !e.is_d});
            check("d_valid", {31'b0, d_valid_o}, {31'b0, e.is_d});
            check(e.is_d ? "d_err" : "f_err",
                  {31'b0, e.is_d ? d_err_o : f_err_o}, {31'b0, e.err});
            check("rdata", rdata_o, e.data);
            last_rdata = e.data;
        end else begin
            check("f_valid_idle", {31'b0, f_valid_o}, 32'd0);
            check("d_valid_idle", {31'b0, d_valid_o}, 32'd0);
            check("rdata_hold", rdata_o, last_rdata);
        end
    endtask

    // Called just after a rising edge: drive, check grants, advance one cycle,
    // then check the registered response.
    task automatic step(input logic fr, input logic [31:0] fa,
                        input logic dr, input logic [31:0] da, input logic dl,
                        input logic ef, input logic ed);
        f_req_i  = fr;
        f_addr_i = fa;
        d_req_i  = dr;
        d_addr_i = da;
        d_lock_i = dl;
        #1;
        check("f_gnt", {31'b0, f_gnt_o}, {31'b0, ef});
        check("d_gnt", {31'b0, d_gnt_o}, {31'b0, ed});
        check("mem_addr", mem_addr_o, ed ? da : fa);
        if (ed)
            exp_q.push_back(expect_for(1'b1, da));
        else if (ef)
            exp_q.push_back(expect_for(1'b0, fa));
        @(posedge clk_i);
        #1;
        check_resp();
    endtask

    initial begin
        rst_i    = 1'b0;
        f_req_i  = 1'b1;
        f_addr_i = 32'h0;
        d_req_i  = 1'b1;
        d_addr_i = 32'h10;
        d_lock_i = 1'b0;

        // Reset state: grants held low even with requests active.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_f_gnt", {31'b0, f_gnt_o}, 32'd0);
        check("rst_d_gnt", {31'b0, d_gnt_o}, 32'd0);
        check("rst_f_valid", {31'b0, f_valid_o}, 32'd0);
        check("rst_d_valid", {31'b0, d_valid_o}, 32'd0);
        check("rst_errs", {30'b0, f_err_o, d_err_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'h0);
        f_req_i = 1'b0;
        d_req_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk_i);
        #1;
        check_resp();

        // Fetch only, consecutive words.
        step(1, 32'h0, 0, 32'h0, 0, 1, 0);
        step(1, 32'h4, 0, 32'h0, 0, 1, 0);
        step(1, 32'h8, 0, 32'h0, 0, 1, 0);
        step(0, 32'h8, 0, 32'h0, 0, 0, 0);

        // Both requesting: four fetch wins, then starved debug, then fetch.
        step(1, 32'h0C, 1, 32'h40, 0, 1, 0);
        step(1, 32'h10, 1, 32'h40, 0, 1, 0);
        step(1, 32'h14, 1, 32'h40, 0, 1, 0);
        step(1, 32'h18, 1, 32'h40, 0, 1, 0);
        step(1, 32'h1C, 1, 32'h40, 0, 0, 1);
        step(1, 32'h1C, 1, 32'h44, 0, 1, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Debug alone, then lock held across three contested cycles.
        step(0, 32'h0, 1, 32'h20, 1, 0, 1);
        step(1, 32'h30, 1, 32'h24, 1, 0, 1);
        step(1, 32'h30, 1, 32'h28, 1, 0, 1);
        step(1, 32'h30, 1, 32'h2C, 1, 0, 1);
        step(1, 32'h30, 0, 32'h0, 0, 0, 0);
        step(1, 32'h30, 0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Access errors and the last valid word.
        step(1, 32'h2, 0, 32'h0, 0, 1, 0);
        step(1, 32'h80, 0, 32'h0, 0, 1, 0);
        step(1, 32'h7C, 0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 1, 32'h81, 0, 0, 1);
        step(0, 32'h0, 1, 32'h4000_0000, 0, 0, 1);
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Reset during a granted cycle discards the access.
        f_req_i  = 1'b1;
        f_addr_i = 32'h0C;
        #1;
        check("pre_rst_f_gnt", {31'b0, f_gnt_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("in_rst_f_gnt", {31'b0, f_gnt_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("rst_mid_f_valid", {31'b0, f_valid_o}, 32'd0);
        check("rst_mid_rdata", rdata_o, 32'h0);
        check("rst_mid_err", {31'b0, f_err_o}, 32'd0);
        f_req_i    = 1'b0;
        rst_i      = 1'b1;
        last_rdata = '0;
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);
        step(1, 32'h0C, 0, 32'h0, 0, 1, 0);
        step(0, 32'h0, 0, 32'h0, 0, 0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
